// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int FIFO_DEPTH = 64;
  localparam int FIFO_DW    = 8;
  localparam int CNT_W      = 8;
  localparam int OWN_W      = 3;

  // Room for one more beat: the in-flight write is not yet in the occupancy count,
  // so it is added before comparing against the capacity (one extra bit avoids wrap).
  function automatic logic space_ok(
    input logic             full,
    input logic [CNT_W-1:0] cnt,
    input logic             wr_in_flight,
    input logic [CNT_W:0]   depth_lim
  );
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{CNT_W{1'b0}}, wr_in_flight};
    return (!full) && (sum < depth_lim);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: first set request after the last owner, wrapping modulo N_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [OWN_W-1:0] i_last,
  output logic [OWN_W-1:0] o_pick,
  output logic             o_valid
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [2*N_REQ-1:0] w_mask;
  logic [2*N_REQ-1:0] w_cand;

  assign w_dbl  = {i_req, i_req};
  assign w_cand = w_dbl & w_mask;

  // Window over the doubled vector: positions last+1 .. last+N_REQ
  always_comb begin
    w_mask = '0;
    for (int j = 0; j < 2*N_REQ; j++) begin
      w_mask[j] = (j > int'(i_last)) && (j <= int'(i_last) + N_REQ);
    end
  end

  // Lowest set candidate wins; scanning downward lets the lowest overwrite last
  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    for (int j = 2*N_REQ-1; j >= 0; j--) begin
      o_pick  = w_cand[j] ? ((j >= N_REQ) ? OWN_W'(j - N_REQ) : OWN_W'(j)) : o_pick;
      o_valid = o_valid | w_cand[j];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ producers.
// Owner is chosen only in IDLE, so a burst is never interleaved with another requester.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DW        = FIFO_DW,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic                fifo_wr_en,
  output logic [DW-1:0]       fifo_buf_in,
  input  logic                fifo_buf_full,
  input  logic [CNT_W-1:0]    fifo_counter,
  output logic [OWN_W-1:0]    owner,
  output logic                busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [OWN_W-1:0] RST_OWNER = OWN_W'(N_REQ - 1);
  localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W+1)'(DEPTH);

  arb_state_e       r_state;
  arb_state_e       w_next_state;
  logic [OWN_W-1:0] r_owner;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_wr_en;
  logic [DW-1:0]    r_buf_in;

  logic             w_own_req;
  logic [DW-1:0]    w_own_data;
  logic             w_space_ok;
  logic             w_accept;
  logic [OWN_W-1:0] w_pick;
  logic             w_pick_valid;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .i_req   (req),
    .i_last  (r_owner),
    .o_pick  (w_pick),
    .o_valid (w_pick_valid)
  );

  assign w_space_ok = space_ok(fifo_buf_full, fifo_counter, r_wr_en, DEPTH_LIM);
  assign w_accept   = (r_state == BURST) && w_own_req && w_space_ok;

  assign fifo_wr_en  = r_wr_en;
  assign fifo_buf_in = r_buf_in;
  assign owner       = r_owner;
  assign busy        = (r_state == BURST);

  // AND-OR mux of the current owner's request and data; only indices below N_REQ match
  always_comb begin
    w_own_req  = 1'b0;
    w_own_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_own_req  = w_own_req  | (req[i] & (r_owner == OWN_W'(i)));
      w_own_data = w_own_data | (req_data[i*DW +: DW] & {DW{r_owner == OWN_W'(i)}});
    end
  end

  // One-hot grant to the owner whenever its beat is accepted
  always_comb begin
    gnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i] = w_accept && (r_owner == OWN_W'(i));
    end
  end

  // Next-state: arbitrate in IDLE, leave BURST on release or after the last allowed beat
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_next_state = BURST;
        end else begin
          w_next_state = IDLE;
        end
      end
      BURST: begin
        if (!w_own_req) begin
          w_next_state = IDLE;
        end else if (w_accept && (r_beat_cnt == LAST_BEAT)) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = BURST;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Ownership latched at arbitration; beat counter restarts with each new burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= RST_OWNER;
      r_beat_cnt <= '0;
    end else if ((r_state == IDLE) && w_pick_valid) begin
      r_owner    <= w_pick;
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

  // Output register stage: accepted beat reaches the FIFO one cycle later; data holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en  <= 1'b0;
      r_buf_in <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_buf_in <= w_own_data;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer queues, a FIFO occupancy model,
// and grant/busy traces used to check burst structure.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [2:0]    id;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  gnt;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_buf_in;
  logic          fifo_buf_full;
  logic [7:0]    fifo_counter;
  logic [2:0]    owner;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] src_q [N][$];
  beat_t         exp_q[$];
  int            m_cnt;
  bit            m_prev_wr;
  int            n_writes;
  int            g_trace[$];
  bit            b_trace[$];
  int            bo[$];
  int            bl[$];

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .DW        (DW),
    .DEPTH     (DEPTH),
    .MAX_BURST (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_buf_in   (fifo_buf_in),
    .fifo_buf_full (fifo_buf_full),
    .fifo_counter  (fifo_counter),
    .owner         (owner),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    fifo_counter  = 8'(m_cnt);
    fifo_buf_full = (m_cnt >= DEPTH);
    for (int i = 0; i < N; i++) begin
      req[i] = (src_q[i].size() > 0);
      req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) e = 1'b0;
    end
    return e;
  endfunction

  // One clock: FIFO absorbs last cycle's write, check emerging write, drive, observe grant
  task automatic step();
    beat_t e;
    int    gid;
    @(posedge clk);
    #1;
    if (m_prev_wr) begin
      check_eq("no_overflow", 32'(m_cnt < DEPTH), 32'd1);
      m_cnt++;
    end
    m_prev_wr = fifo_wr_en;
    if (fifo_wr_en) begin
      n_writes++;
      check_eq("sb_inflight", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("wr_data", 32'(fifo_buf_in), 32'(e.data));
        check_eq("wr_owner", 32'(owner), 32'(e.id));
      end
    end
    drive();
    #1;
    gid = -1;
    if (gnt != '0) begin
      check_eq("gnt_onehot", 32'($onehot(gnt)), 32'd1);
      check_eq("gnt_has_req", 32'(gnt & ~req), 32'd0);
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) gid = i;
      end
      if (src_q[gid].size() > 0) begin
        e.id   = 3'(gid);
        e.data = src_q[gid].pop_front();
        exp_q.push_back(e);
      end
    end
    g_trace.push_back(gid);
    b_trace.push_back(busy);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (!(all_empty() && (exp_q.size() == 0) && !m_prev_wr) && (k < budget)) begin
      step();
      k++;
    end
    check_eq("drain_timeout", 32'(k < budget), 32'd1);
  endtask

  task automatic analyze();
    int prev;
    prev = -1;
    bo.delete();
    bl.delete();
    foreach (g_trace[k]) begin
      if (g_trace[k] >= 0) begin
        if (g_trace[k] == prev) begin
          bl[bl.size()-1] = bl[bl.size()-1] + 1;
        end else begin
          bo.push_back(g_trace[k]);
          bl.push_back(1);
        end
      end
      prev = g_trace[k];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    m_cnt     = 0;
    m_prev_wr = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    g_trace.delete();
    b_trace.delete();
    n_writes = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int f;
    int l;
    int gaps;
    int k;
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    fifo_buf_full = 1'b0;
    fifo_counter = 8'd0;

    // Test 1: reset values with all requesting, bubble after release, rotation 0..3
    do_reset();
    for (int i = 0; i < N; i++) src_q[i].push_back(8'(8'hA0 + i));
    drive();
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check_eq("rst_owner", 32'(owner), 32'd3);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_gnt", 32'(gnt), 32'd0);
    check_eq("post_rst_wr", 32'(fifo_wr_en), 32'd0);
    drain(100);
    analyze();
    check_eq("t1_bursts", 32'(bo.size()), 32'd4);
    for (int i = 0; i < 4 && i < bo.size(); i++) check_eq("t1_owner_seq", 32'(bo[i]), 32'(i));
    check_eq("t1_writes", 32'(n_writes), 32'd4);

    // Test 2: single requester 2 streams 16 beats as two bursts of 8
    do_reset();
    for (int k2 = 0; k2 < 16; k2++) src_q[2].push_back(8'(8'h10 + k2));
    drive();
    rst_n = 1'b1;
    drain(200);
    analyze();
    check_eq("t2_bursts", 32'(bo.size()), 32'd2);
    for (int i = 0; i < bo.size(); i++) begin
      check_eq("t2_owner", 32'(bo[i]), 32'd2);
      check_eq("t2_len", 32'(bl[i]), 32'd8);
    end
    f = -1;
    l = -1;
    foreach (g_trace[i]) begin
      if (g_trace[i] >= 0) begin
        if (f < 0) f = i;
        l = i;
      end
    end
    gaps = 0;
    for (int i = f; i <= l && f >= 0; i++) if (g_trace[i] < 0) gaps++;
    check_eq("t2_mid_bubble", 32'(gaps), 32'd1);
    check_eq("t2_writes", 32'(n_writes), 32'd16);
    check_eq("t2_owner_reg", 32'(owner), 32'd2);

    // Test 3: all four continuously requesting -> owners 0,1,2,3,0,... bursts of 8
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k2 = 0; k2 < 16; k2++) src_q[i].push_back(8'(8'h40 + i*16 + k2));
    drive();
    rst_n = 1'b1;
    drain(400);
    analyze();
    check_eq("t3_bursts", 32'(bo.size()), 32'd8);
    for (int i = 0; i < bo.size(); i++) begin
      check_eq("t3_owner_seq", 32'(bo[i]), 32'(i % 4));
      check_eq("t3_len", 32'(bl[i]), 32'd8);
    end
    check_eq("t3_writes", 32'(n_writes), 32'd64);

    // Test 4: FIFO at 62 -> exactly two writes, stall, resume when space appears
    do_reset();
    m_cnt = 62;
    for (int k2 = 0; k2 < 4; k2++) src_q[0].push_back(8'(8'h80 + k2));
    drive();
    rst_n = 1'b1;
    repeat (10) step();
    check_eq("t4_writes_to_full", 32'(n_writes), 32'd2);
    check_eq("t4_stall_gnt", 32'(gnt), 32'd0);
    check_eq("t4_stall_wr", 32'(fifo_wr_en), 32'd0);
    check_eq("t4_stall_busy", 32'(busy), 32'd1);
    m_cnt = 61;
    step();
    check_eq("t4_resume_gnt", 32'(g_trace[g_trace.size()-1]), 32'd0);
    drain(50);
    check_eq("t4_writes_total", 32'(n_writes), 32'd4);

    // Test 5: owner 1 releases after 3 beats; owner 2 gets a full burst after one IDLE bubble
    do_reset();
    for (int k2 = 0; k2 < 3; k2++) src_q[1].push_back(8'(8'h21 + k2));
    for (int k2 = 0; k2 < 10; k2++) src_q[2].push_back(8'(8'h30 + k2));
    drive();
    rst_n = 1'b1;
    drain(200);
    p = -1;
    foreach (g_trace[i]) if (g_trace[i] == 1) p = i;
    if (p >= 0 && p + 3 < g_trace.size()) begin
      check_eq("t5_drop_cycle_busy", 32'(b_trace[p+1]), 32'd1);
      check_eq("t5_drop_cycle_gnt", 32'(g_trace[p+1]), 32'hFFFF_FFFF);
      check_eq("t5_idle_busy", 32'(b_trace[p+2]), 32'd0);
      check_eq("t5_idle_gnt", 32'(g_trace[p+2]), 32'hFFFF_FFFF);
      check_eq("t5_next_gnt", 32'(g_trace[p+3]), 32'd2);
    end else begin
      check_eq("t5_trace_len", 32'(p), 32'(g_trace.size()));
    end
    analyze();
    check_eq("t5_bursts", 32'(bo.size()), 32'd3);
    if (bo.size() >= 2) begin
      check_eq("t5_first_owner", 32'(bo[0]), 32'd1);
      check_eq("t5_first_len", 32'(bl[0]), 32'd3);
      check_eq("t5_second_owner", 32'(bo[1]), 32'd2);
      check_eq("t5_second_len", 32'(bl[1]), 32'd8);
    end

    // Test 6: reset while a write is on the port clears it at once
    do_reset();
    for (int k2 = 0; k2 < 5; k2++) begin
      src_q[0].push_back(8'(8'h50 + k2));
      src_q[2].push_back(8'(8'h60 + k2));
    end
    drive();
    rst_n = 1'b1;
    k = 0;
    while (!fifo_wr_en && k < 20) begin
      step();
      k++;
    end
    check_eq("t6_wr_seen", 32'(fifo_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_wr", 32'(fifo_wr_en), 32'd0);
    check_eq("t6_async_busy", 32'(busy), 32'd0);
    check_eq("t6_async_owner", 32'(owner), 32'd3);
    check_eq("t6_async_gnt", 32'(gnt), 32'd0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    m_prev_wr = 1'b0;
    src_q[1].push_back(8'h71);
    src_q[1].push_back(8'h72);
    src_q[3].push_back(8'h73);
    src_q[3].push_back(8'h74);
    drive();
    g_trace.delete();
    b_trace.delete();
    n_writes = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain(100);
    analyze();
    check_eq("t6_bursts", 32'(bo.size()), 32'd2);
    if (bo.size() >= 2) begin
      check_eq("t6_first_owner", 32'(bo[0]), 32'd1);
      check_eq("t6_second_owner", 32'(bo[1]), 32'd3);
    end
    check_eq("t6_writes", 32'(n_writes), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
